// File: rtl/on_chip_memory_18kx2.sv
// 1024x18 simple dual-port RAM (write port A, read port B) built from two 512x18 banks.
// Define OUT_REG_EN to add a second output register stage (2-clock read latency).
module on_chip_memory_18kx2 #(
  parameter int DATA_WIDTH      = 18,
  parameter int ADDR_WIDTH      = 10,
  parameter int BANK_ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_A,
  input  logic [DATA_WIDTH-1:0] din_A,
  input  logic                  wen_A,
  input  logic [ADDR_WIDTH-1:0] addr_B,
  input  logic                  ren_B,
  output logic [DATA_WIDTH-1:0] dout_B
);

  localparam int BANK_DEPTH = 2 ** BANK_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] bank0_mem [BANK_DEPTH];
  logic [DATA_WIDTH-1:0] bank1_mem [BANK_DEPTH];

  logic [BANK_ADDR_WIDTH-1:0] row_a;
  logic [BANK_ADDR_WIDTH-1:0] row_b;
  logic                       bank_a;
  logic                       bank_b;

  assign row_a  = addr_A[BANK_ADDR_WIDTH-1:0];
  assign row_b  = addr_B[BANK_ADDR_WIDTH-1:0];
  assign bank_a = addr_A[ADDR_WIDTH-1];
  assign bank_b = addr_B[ADDR_WIDTH-1];

  // Memory arrays carry no reset; writes proceed even while rst is high.
  always_ff @(posedge clk) begin
    if (wen_A) begin
      if (bank_a) bank1_mem[row_a] <= din_A;
      else        bank0_mem[row_a] <= din_A;
    end
  end

  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  bank_sel_q, bank_sel_d;

  // Both banks are read in parallel; a concurrent write forwards din_A to either bank slot.
  always_comb begin
    rd0_d      = rd0_q;
    rd1_d      = rd1_q;
    bank_sel_d = bank_sel_q;
    if (ren_B) begin
      rd0_d      = wen_A ? din_A : bank0_mem[row_b];
      rd1_d      = wen_A ? din_A : bank1_mem[row_b];
      bank_sel_d = bank_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_q      <= '0;
      rd1_q      <= '0;
      bank_sel_q <= 1'b0;
    end else begin
      rd0_q      <= rd0_d;
      rd1_q      <= rd1_d;
      bank_sel_q <= bank_sel_d;
    end
  end

  logic [DATA_WIDTH-1:0] rd_mux;
  assign rd_mux = bank_sel_q ? rd1_q : rd0_q;

`ifdef OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= rd_mux;
  end

  assign dout_B = out_q;
`else
  assign dout_B = rd_mux;
`endif

endmodule

// File: tb/tb_on_chip_memory_18kx2.sv
// Directed bench for on_chip_memory_18kx2 with a reference memory model and expected-value queue.
module tb_on_chip_memory_18kx2;

`ifdef OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [9:0]  addr_A;
  logic [17:0] din_A;
  logic        wen_A;
  logic [9:0]  addr_B;
  logic        ren_B;
  logic [17:0] dout_B;

  int checks = 0;
  int errors = 0;

  logic [17:0] model_mem [1024];
  logic [17:0] model_dout;
  logic [17:0] exp_q [$];

  on_chip_memory_18kx2 dut (
    .clk    (clk),
    .rst    (rst),
    .addr_A (addr_A),
    .din_A  (din_A),
    .wen_A  (wen_A),
    .addr_B (addr_B),
    .ren_B  (ren_B),
    .dout_B (dout_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] expected);
    checks++;
    assert (dout_B === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, dout_B, expected);
    end
  endtask

  // One clock: drive at negedge, update the model at the edge, compare against the queue.
  task automatic step(input logic r, input logic we, input logic [9:0] aa, input logic [17:0] d,
                      input logic re, input logic [9:0] ab);
    logic [17:0] expected;
    @(negedge clk);
    rst = r; wen_A = we; addr_A = aa; din_A = d; ren_B = re; addr_B = ab;
    @(posedge clk);
    if (r)       model_dout = '0;
    else if (re) model_dout = we ? d : model_mem[ab];
    if (we) model_mem[aa] = d;
    exp_q.push_back(model_dout);
    #1;
    expected = exp_q.pop_front();
    if (r) expected = '0;
    check("scoreboard", expected);
  endtask

  task automatic wr(input logic [9:0] a, input logic [17:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 10'($urandom_range(0, 1023)));
  endtask

  task automatic rd(input logic [9:0] a);
    step(1'b0, 1'b0, 10'd0, 18'd0, 1'b1, a);
  endtask

  task automatic drain;
    for (int k = 0; k < LAT - 1; k++)
      step(1'b0, 1'b0, 10'd0, 18'd0, 1'b0, 10'($urandom_range(0, 1023)));
  endtask

  initial begin
    rst = 1'b0; wen_A = 1'b0; addr_A = '0; din_A = '0; ren_B = 1'b0; addr_B = '0;
    for (int k = 0; k < LAT - 1; k++) exp_q.push_back(18'd0);

    // Reset with a read pending: output must be zero.
    step(1'b1, 1'b0, 10'd0, 18'd0, 1'b1, 10'd3);
    check("reset_zero", 18'd0);

    // Fill every address; output must stay at zero while ren_B is low.
    for (int i = 0; i < 1024; i++) wr(10'(i), 18'($urandom_range(0, 18'h3FFFF)));
    check("fill_hold", 18'd0);

    for (int i = 0; i < 1024; i++) rd(10'(i));
    drain();

    // Reset mid-run, then confirm contents survived.
    step(1'b1, 1'b0, 10'd0, 18'd0, 1'b1, 10'd77);
    check("reset_again", 18'd0);
    rd(10'd77);
    drain();

    // Bank boundary.
    wr(10'd511, 18'h3FFFF);
    wr(10'd512, 18'h00001);
    rd(10'd511);
    drain();
    check("bank_511", 18'h3FFFF);
    rd(10'd512);
    drain();
    check("bank_512", 18'h00001);

    // Write-through with unrelated read address.
    step(1'b0, 1'b1, 10'd5, 18'h2AAAA, 1'b1, 10'd700);
    drain();
    check("write_through", 18'h2AAAA);
    rd(10'd5);
    drain();
    check("wt_stored", 18'h2AAAA);

    // Hold while ren_B is low.
    wr(10'd40, 18'h12345);
    rd(10'd40);
    drain();
    check("hold_start", 18'h12345);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 10'd0, 18'd0, 1'b0, 10'($urandom_range(0, 1023)));
      check("hold", 18'h12345);
    end

    // Write then read on the next cycle.
    wr(10'd300, 18'h15555);
    rd(10'd300);
    drain();
    check("wr_then_rd", 18'h15555);

    // Write during reset is still performed.
    step(1'b1, 1'b1, 10'd900, 18'h0BEEF, 1'b0, 10'd0);
    rd(10'd900);
    drain();
    check("wr_in_reset", 18'h0BEEF);

    if (exp_q.size() != LAT - 1) begin
      errors++;
      $error("FAIL queue_depth: observed %0d expected %0d", exp_q.size(), LAT - 1);
    end
    checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
